// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the alu_pipe slice.
//   alu_op_e     : ARM data-processing opcode encoding (AND=0 .. MVN=15)
//   FLAG_N..V    : bit positions of each flag inside the 4-bit NZCV vector
//   is_test_op() : true for TST/TEQ/CMP/CMN (flags only, no result write)
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN occupy opcodes 8..11
  function automatic logic is_test_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core -- purely combinational data-processing unit.
// Ports:
//   opcode           in  : ARM data-processing opcode
//   operand_a        in  : Rn value
//   operand_b        in  : shifted operand2
//   shifter_carry    in  : barrel-shifter carry-out (C for logical ops)
//   set_flags        in  : S bit
//   flags            in  : current NZCV register (carry-in and preserved V)
//   result           out : computed value
//   flags_next       out : NZCV after this op
//   result_writeback out : op writes a destination register
//   nzcv_writeback   out : op updates the flag register
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             shifter_carry,
  input  logic             set_flags,
  input  logic [3:0]       flags,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_next,
  output logic             result_writeback,
  output logic             nzcv_writeback
);

  alu_op_e          op;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic             arith;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;

  assign op = alu_op_e'(opcode);

  // All arithmetic ops share one adder: subtraction is x + ~y + 1, and the
  // borrow-in variants replace the +1 with the flag-register carry, so the
  // adder carry-out is directly the ARM C (NOT borrow) in every case.
  always_comb begin
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    arith     = 1'b0;
    logic_res = '0;
    case (op)
      OP_ADD, OP_CMN: begin add_x = operand_a; add_y = operand_b;  add_cin = 1'b0;          arith = 1'b1; end
      OP_ADC:         begin add_x = operand_a; add_y = operand_b;  add_cin = flags[FLAG_C]; arith = 1'b1; end
      OP_SUB, OP_CMP: begin add_x = operand_a; add_y = ~operand_b; add_cin = 1'b1;          arith = 1'b1; end
      OP_SBC:         begin add_x = operand_a; add_y = ~operand_b; add_cin = flags[FLAG_C]; arith = 1'b1; end
      OP_RSB:         begin add_x = operand_b; add_y = ~operand_a; add_cin = 1'b1;          arith = 1'b1; end
      OP_RSC:         begin add_x = operand_b; add_y = ~operand_a; add_cin = flags[FLAG_C]; arith = 1'b1; end
      OP_AND, OP_TST: logic_res = operand_a & operand_b;
      OP_EOR, OP_TEQ: logic_res = operand_a ^ operand_b;
      OP_ORR:         logic_res = operand_a | operand_b;
      OP_MOV:         logic_res = operand_b;
      OP_BIC:         logic_res = operand_a & ~operand_b;
      OP_MVN:         logic_res = ~operand_b;
      default:        logic_res = '0;
    endcase

    sum    = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    result = arith ? sum[WIDTH-1:0] : logic_res;
    carry  = arith ? sum[WIDTH] : shifter_carry;
    // Signed overflow: both adder inputs agree in sign but the sum does not.
    ovf    = arith ? ((add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]))
                   : flags[FLAG_V];

    flags_next         = '0;
    flags_next[FLAG_N] = result[WIDTH-1];
    flags_next[FLAG_Z] = (result == '0);
    flags_next[FLAG_C] = carry;
    flags_next[FLAG_V] = ovf;
  end

  assign result_writeback = !is_test_op(opcode);
  assign nzcv_writeback   = is_test_op(opcode) || set_flags;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- single-stage pipelined ALU with valid/ready handshake and an
// NZCV flag register updated at the acceptance edge.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   in_valid / in_ready           : operation handshake
//   opcode, operand_a, operand_b  : operation and operands
//   shifter_carry, set_flags      : logical-op carry, S bit
//   flag_wr_en / flag_wr_data     : direct NZCV load (blocks acceptance that cycle)
//   out_valid / out_ready         : result handshake
//   result, result_writeback,
//   nzcv_writeback                : registered result and its qualifiers
//   nzcv                          : current flag register {N,Z,C,V}
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             shifter_carry,
  input  logic             set_flags,
  input  logic             flag_wr_en,
  input  logic [3:0]       flag_wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_writeback,
  output logic             nzcv_writeback,
  output logic [3:0]       nzcv
);

  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;
  logic             core_rwb;
  logic             core_nwb;
  logic             accept;

  // Flags feed the core straight from the register, so an op accepted the
  // cycle after a flag-setting op already sees the updated carry.
  alu_core #(.WIDTH(WIDTH)) u_core (
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .shifter_carry    (shifter_carry),
    .set_flags        (set_flags),
    .flags            (nzcv),
    .result           (core_result),
    .flags_next       (core_flags),
    .result_writeback (core_rwb),
    .nzcv_writeback   (core_nwb)
  );

  // A direct flag write owns the flag register for its cycle, so no op may
  // be accepted alongside it.
  assign in_ready = (!out_valid || out_ready) && !flag_wr_en;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid        <= 1'b0;
      result           <= '0;
      result_writeback <= 1'b0;
      nzcv_writeback   <= 1'b0;
    end else if (accept) begin
      out_valid        <= 1'b1;
      result           <= core_result;
      result_writeback <= core_rwb;
      nzcv_writeback   <= core_nwb;
    end else if (out_ready) begin
      out_valid        <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv <= 4'b0000;
    end else if (flag_wr_en) begin
      nzcv <= flag_wr_data;
    end else if (accept && core_nwb) begin
      nzcv <= core_flags;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- directed, table-driven bench for alu_pipe (WIDTH=32),
// plus hand-written sequences for back-to-back, stall, reset and
// flag-write corner cases.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = 4'h0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        shifter_carry = 1'b0;
  logic        set_flags = 1'b0;
  logic        flag_wr_en = 1'b0;
  logic [3:0]  flag_wr_data = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        result_writeback;
  logic        nzcv_writeback;
  logic [3:0]  nzcv;

  int n_run  = 0;
  int n_fail = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .shifter_carry    (shifter_carry),
    .set_flags        (set_flags),
    .flag_wr_en       (flag_wr_en),
    .flag_wr_data     (flag_wr_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .result_writeback (result_writeback),
    .nzcv_writeback   (nzcv_writeback),
    .nzcv             (nzcv)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        mon_en = 1'b0;
  logic [31:0] mon_q[$];
  always @(posedge clk) begin
    if (mon_en && out_valid && out_ready) mon_q.push_back(result);
  end

  typedef struct {
    logic [3:0]  init;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        shc;
    logic        s;
    logic [31:0] res;
    logic        rwb;
    logic        nwb;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [3:0] init, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic shc, input logic s, input logic [31:0] res,
                              input logic rwb, input logic nwb, input logic [3:0] flags);
    vec_t v;
    v.init = init; v.op = op; v.a = a; v.b = b; v.shc = shc; v.s = s;
    v.res = res; v.rwb = rwb; v.nwb = nwb; v.flags = flags;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic shc, input logic s);
    opcode = op; operand_a = a; operand_b = b; shifter_carry = shc; set_flags = s;
  endtask

  initial begin
    //               init    op      a             b             shc   s     res           rwb   nwb   nzcv
    vecs[0]  = mk(4'b0000, OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 4'b1001);
    vecs[1]  = mk(4'b0000, OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 4'b0110);
    vecs[2]  = mk(4'b0010, OP_ADC, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000001, 1'b1, 1'b0, 4'b0010);
    vecs[3]  = mk(4'b0000, OP_CMP, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 4'b1000);
    vecs[4]  = mk(4'b0000, OP_SUB, 32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b1, 4'b0010);
    vecs[5]  = mk(4'b0000, OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 4'b0011);
    vecs[6]  = mk(4'b0000, OP_SBC, 32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b1, 4'b0010);
    vecs[7]  = mk(4'b0010, OP_SBC, 32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b1, 4'b0010);
    vecs[8]  = mk(4'b0000, OP_RSB, 32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b1, 4'b0010);
    vecs[9]  = mk(4'b1111, OP_RSC, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 32'h00000002, 1'b1, 1'b0, 4'b1111);
    vecs[10] = mk(4'b0000, OP_CMN, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 4'b0110);
    vecs[11] = mk(4'b0001, OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b1, 32'hF000F000, 1'b1, 1'b1, 4'b1011);
    vecs[12] = mk(4'b0100, OP_EOR, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 1'b0, 32'hF0F00F0F, 1'b1, 1'b0, 4'b0100);
    vecs[13] = mk(4'b0000, OP_ORR, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 4'b0100);
    vecs[14] = mk(4'b0011, OP_BIC, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b1, 32'hFFFF0000, 1'b1, 1'b1, 4'b1001);
    vecs[15] = mk(4'b0000, OP_MOV, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1, 4'b0110);
    vecs[16] = mk(4'b0000, OP_MVN, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 4'b1000);
    vecs[17] = mk(4'b0000, OP_TST, 32'h0000000F, 32'h000000F0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 4'b0110);
    vecs[18] = mk(4'b0001, OP_TEQ, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 4'b0101);
    vecs[19] = mk(4'b0000, OP_ADC, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 4'b0000);
    vecs[20] = mk(4'b0000, OP_ADD, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 4'b0111);

    // reset state
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_rwb", result_writeback, 1'b0);
    check("rst_nwb", nzcv_writeback, 1'b0);
    check("rst_nzcv", nzcv, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_release_in_ready", in_ready, 1'b1);

    // table: preload flags, issue one op, check registered outputs
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b0; flag_wr_en = 1'b1; flag_wr_data = vecs[i].init;
      @(negedge clk);
      flag_wr_en = 1'b0; in_valid = 1'b1;
      drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shc, vecs[i].s);
      #1 check($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_out_valid", i), out_valid, 1'b1);
      if (vecs[i].rwb) check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_rwb", i), result_writeback, vecs[i].rwb);
      check($sformatf("v%0d_nwb", i), nzcv_writeback, vecs[i].nwb);
      check($sformatf("v%0d_nzcv", i), nzcv, vecs[i].flags);
    end

    // ADDS carry-out consumed by back-to-back ADC
    @(negedge clk);
    flag_wr_en = 1'b1; flag_wr_data = 4'b0000;
    @(negedge clk);
    flag_wr_en = 1'b0; in_valid = 1'b1;
    drive_op(OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1);
    @(negedge clk);
    drive_op(OP_ADC, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("b2b_adds_result", result, 32'h0);
    check("b2b_adds_nzcv", nzcv, 4'b0110);
    check("b2b_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_adc_valid", out_valid, 1'b1);
    check("b2b_adc_result", result, 32'h1);

    // CMP then MOVS back-to-back
    @(negedge clk);
    in_valid = 1'b1;
    drive_op(OP_CMP, 32'h3, 32'h5, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(OP_MOV, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    check("cmp_rwb", result_writeback, 1'b0);
    check("cmp_nwb", nzcv_writeback, 1'b1);
    check("cmp_nzcv", nzcv, 4'b1000);
    @(negedge clk);
    in_valid = 1'b0;
    check("movs_nzcv", nzcv, 4'b0110);
    check("movs_rwb", result_writeback, 1'b1);
    check("movs_result", result, 32'h0);

    // direct flag write collides with an offered ADC
    @(negedge clk);
    flag_wr_en = 1'b1; flag_wr_data = 4'b0010; in_valid = 1'b1;
    drive_op(OP_ADC, 32'h1, 32'h1, 1'b0, 1'b0);
    #1 check("fw_in_ready_blocked", in_ready, 1'b0);
    @(negedge clk);
    flag_wr_en = 1'b0;
    #1;
    check("fw_in_ready_next", in_ready, 1'b1);
    check("fw_nzcv", nzcv, 4'b0010);
    check("fw_no_accept", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("fw_adc_valid", out_valid, 1'b1);
    check("fw_adc_result", result, 32'h3);

    // stall: first result held, second accepted only after drain
    @(negedge clk);
    mon_q.delete();
    mon_en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    drive_op(OP_ADD, 32'd10, 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(OP_ADD, 32'd20, 32'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d_valid", k), out_valid, 1'b1);
      check($sformatf("stall%0d_result", k), result, 32'd11);
      check($sformatf("stall%0d_in_ready", k), in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("stall_release_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_second_valid", out_valid, 1'b1);
    check("stall_second_result", result, 32'd22);
    @(negedge clk);
    check("stall_drained", out_valid, 1'b0);
    mon_en = 1'b0;
    check("stall_count", mon_q.size(), 2);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stall_seq%0d", k), (k < mon_q.size()) ? mon_q[k] : 32'hDEADBEEF,
            (k == 0) ? 32'd11 : 32'd22);
    end

    // asynchronous reset while a result is stalled
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    drive_op(OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst2_pre_valid", out_valid, 1'b1);
    check("rst2_pre_nzcv", nzcv, 4'b0110);
    #1 reset = 1'b1;
    #1;
    check("rst2_valid", out_valid, 1'b0);
    check("rst2_nzcv", nzcv, 4'b0000);
    check("rst2_result", result, 32'h0);
    check("rst2_rwb", result_writeback, 1'b0);
    check("rst2_nwb", nzcv_writeback, 1'b0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    #1 check("rst2_in_ready", in_ready, 1'b1);
    @(negedge clk);
    check("rst2_no_output", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
